xsleena_core_rgb_lut_pipe: RTL and testbench
============================================

# xsleena_core_rgb_lut_pipe

Parametrised, pipelined colour expander for N channels: each channel's IN_W-bit palette code is translated to an OUT_W-bit DAC level through a per-channel writable table. It sits between the palette RAM output and the video output/scaler. On reset it fills every table with a bit-replication ramp. It adds per-pixel blanking and a half-intensity dim mode, none of which the fixed 4→8 LUT has.

## Interface
- IN_W, 4, input code width per channel (2..6)
- OUT_W, 8, output level width per channel (IN_W..10)
- NCH, 3, channel count (1..4); channel 0 occupies the LSBs of packed buses
- clk  in  1  pixel-domain clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  pixel strobe for col_in/blank/dim
- blank  in  1  force this pixel's output to zero
- dim  in  1  halve this pixel's output levels
- col_in  in  NCH*IN_W  packed input codes
- wr_en  in  1  table write request
- wr_ch  in  2  target channel; values >= NCH are ignored
- wr_addr  in  IN_W  table entry
- wr_data  in  OUT_W  new level
- wr_ready  out  1  table accepts writes (0 during init)
- busy  out  1  init sequencer active
- out_valid  out  1  pixel strobe, pix_valid delayed 2 cycles
- col_out  out  NCH*OUT_W  packed output levels

## Operation
- States: INIT, RUN. rst forces INIT with init address 0. Reset has priority over every other input.
- INIT:
  - Each cycle writes the default value to entry addr of every channel, then increments addr.
  - After entry 2^IN_W-1 is written, the block moves to RUN on the next edge. INIT takes exactly 2^IN_W cycles.
  - Default value = the IN_W-bit code replicated MSB-first and truncated to OUT_W bits. For IN_W=4, OUT_W=8: code 0x5 gives 0x55 and 0xF gives 0xFF.
- busy=1 in INIT, 0 in RUN. wr_ready = !busy. A wr_en asserted while busy is dropped; it is not queued.
- RUN write: wr_en=1 with wr_ch<NCH writes wr_data into table[wr_ch][wr_addr] at the edge. wr_ch>=NCH is a no-op.
- Pixel pipeline (registered, no stalls):
  - Stage 1: per channel, registered table read at col_in code. blank, dim and valid are registered alongside.
  - Stage 2: level = blank ? 0 : (dim ? level>>1 : level), registered into col_out. out_valid is registered.
- While busy, stage-1 data is forced to 0. out_valid still follows pix_valid.
- When pix_valid=0, stage registers hold their previous data. out_valid=0 and col_out holds its last value.
- Same-cycle write and read of the same entry: the read returns the old value (read-before-write). The new value is visible to pixels presented on the next cycle or later.
- Tables may be inferred as distributed or block RAM, but must provide 1 write port, NCH read ports, and 1-cycle read latency.

## Timing
- Reset values: out_valid=0, col_out=0, busy=1, wr_ready=0, all pipeline registers 0. Table contents are undefined until INIT completes.
- The first edge with rst=0 writes entry 0. busy falls after edge 2^IN_W, counting from the first non-reset edge.
- Latency: a pixel presented at edge k appears on col_out/out_valid after edge k+2. Throughput is 1 pixel per clock.
- rst asserted mid-INIT or mid-RUN restarts INIT from address 0, clears the pipeline, and discards any in-flight pixels.
- Write latency: a write accepted at edge k affects pixels sampled at edge k+1 or later.
- blank and dim are sampled with their pixel; changing them has no effect on pixels already in flight.

## Test plan
- Reset/init (IN_W=4, OUT_W=8, NCH=3): hold rst 3 cycles, then release. Required: busy=1 for exactly 16 cycles and wr_ready=0 throughout. col_in=0x5A3 after init gives col_out=0x55AA33 two cycles later.
- Program resistor curve: write channel 0 entries 0..15 with 00,10,20,30,3E,4E,5E,6E,91,A1,B1,C1,CF,DF,EF,FF. Sweep col_in ch0 from 0 to F. Required: col_out[7:0] matches the written list with 2-cycle latency; ch1 and ch2 keep the replication ramp.
- Blank/dim: col_in=0xFFF gives 0xFFFFFF. With dim=1 it gives 0x7F7F7F. With blank=1 and dim=1 it gives 0x000000. Alternate these every cycle; each output must correspond to its own input pixel.
- Write collision: table[1][7]=0x77; write 0x12 to [1][7] on the same edge that samples col_in ch1=7. Required: that pixel outputs 0x77 and the next pixel outputs 0x12. A write with wr_ch=3 changes nothing.
- Write during init: assert wr_en while busy. Required: the entry holds the default ramp value after init.
- Mid-run reset: stream 10 valid pixels and assert rst on pixel 5. Required: out_valid=0 the cycle after rst, busy=1, programmed entries revert to defaults, and no stale pixel emerges.

Source files
------------

// File: rtl/xsleena_core_rgb_lut_pipe_if.sv
// Pixel and table-write bus for the RGB LUT expander.
// The master drives pixels and writes; the slave returns levels and status.
interface xsleena_core_rgb_lut_pipe_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int NCH   = 3
);
  logic                  pix_valid;
  logic                  blank;
  logic                  dim;
  logic [NCH*IN_W-1:0]   col_in;
  logic                  wr_en;
  logic [1:0]            wr_ch;
  logic [IN_W-1:0]       wr_addr;
  logic [OUT_W-1:0]      wr_data;
  logic                  wr_ready;
  logic                  busy;
  logic                  out_valid;
  logic [NCH*OUT_W-1:0]  col_out;

  modport master (
    output pix_valid, blank, dim, col_in,
    output wr_en, wr_ch, wr_addr, wr_data,
    input  wr_ready, busy, out_valid, col_out
  );

  modport slave (
    input  pix_valid, blank, dim, col_in,
    input  wr_en, wr_ch, wr_addr, wr_data,
    output wr_ready, busy, out_valid, col_out
  );
endinterface

// File: rtl/xsleena_core_rgb_lut_pipe.sv
// Per-channel writable palette-code to DAC-level expander.
// Two-stage pipeline: table read, then blank/dim shaping.
module xsleena_core_rgb_lut_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int NCH   = 3
) (
  input  logic clk,
  input  logic rst,
  xsleena_core_rgb_lut_pipe_if.slave bus
);
  localparam int DEPTH = 2**IN_W;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           r_state;
  logic [IN_W-1:0]      r_iaddr;
  logic                 w_busy;
  logic [OUT_W-1:0]     w_ramp;
  logic                 w_wen;
  logic [NCH*OUT_W-1:0] w_s1_lvl;
  logic                 r_s1_valid;
  logic                 r_s1_blank;
  logic                 r_s1_dim;
  logic [NCH*OUT_W-1:0] w_s2;
  logic                 r_out_valid;
  logic [NCH*OUT_W-1:0] r_col_out;

  assign w_busy = (r_state == S_INIT);
  assign w_wen  = bus.wr_en && !w_busy
               && ({1'b0, bus.wr_ch} < 3'(NCH));

  // init sequencer: walk every entry once, then run
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_iaddr <= '0;
    end else if (r_state == S_INIT) begin
      r_iaddr <= r_iaddr + IN_W'(1);
      if (r_iaddr == {IN_W{1'b1}})
        r_state <= S_RUN;
    end
  end

  // default level: init code replicated MSB-first
  always_comb begin
    w_ramp = '0;
    for (int j = 0; j < OUT_W; j++)
      w_ramp[OUT_W-1-j] = r_iaddr[IN_W-1-(j % IN_W)];
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [OUT_W-1:0] r_tab [DEPTH];
    logic [OUT_W-1:0] r_lvl;

    // table write: ramp fill while busy, host writes after
    always_ff @(posedge clk) begin
      if (!rst) begin
        if (w_busy)
          r_tab[r_iaddr] <= w_ramp;
        else if (w_wen && bus.wr_ch == 2'(g))
          r_tab[bus.wr_addr] <= bus.wr_data;
      end
    end

    // stage 1 read; old data wins on a same-edge write
    always_ff @(posedge clk) begin
      if (rst)
        r_lvl <= '0;
      else if (bus.pix_valid)
        r_lvl <= w_busy ? '0
               : r_tab[bus.col_in[g*IN_W +: IN_W]];
    end

    assign w_s1_lvl[g*OUT_W +: OUT_W] = r_lvl;
  end

  // stage 1 control travels with its pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_blank <= 1'b0;
      r_s1_dim   <= 1'b0;
    end else begin
      r_s1_valid <= bus.pix_valid;
      if (bus.pix_valid) begin
        r_s1_blank <= bus.blank;
        r_s1_dim   <= bus.dim;
      end
    end
  end

  // stage 2 shaping: blank beats dim
  always_comb begin
    w_s2 = '0;
    for (int c = 0; c < NCH; c++)
      w_s2[c*OUT_W +: OUT_W] = r_s1_blank ? '0
        : r_s1_dim ? (w_s1_lvl[c*OUT_W +: OUT_W] >> 1)
        : w_s1_lvl[c*OUT_W +: OUT_W];
  end

  // stage 2 register: output holds when no pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_col_out   <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid)
        r_col_out <= w_s2;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.wr_ready  = !w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.col_out   = r_col_out;
endmodule

// File: tb/tb_xsleena_core_rgb_lut_pipe.sv
// Bench for the RGB LUT expander (IN_W=4, OUT_W=8, NCH=3).
// Expected levels queue at drive time and pop at out_valid.
module tb_xsleena_core_rgb_lut_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  logic [23:0] q[$];

  always #5 clk = ~clk;

  xsleena_core_rgb_lut_pipe_if #(
    .IN_W(4), .OUT_W(8), .NCH(3)) u_if();

  xsleena_core_rgb_lut_pipe #(
    .IN_W(4), .OUT_W(8), .NCH(3)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  typedef struct {
    logic [11:0] col;
    logic        b;
    logic        d;
    logic [23:0] exp;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, a, x);
    end
  endtask

  function automatic logic [7:0] rp(input logic [3:0] c);
    return {c, c};
  endfunction

  // scoreboard pop on every output pixel
  always @(negedge clk) begin
    if (u_if.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL stale_pixel: got %h, required none",
                 u_if.col_out);
      end else begin
        chk("pixel", 32'(u_if.col_out), 32'(q.pop_front()));
      end
    end
  end

  task automatic step(input logic v, input logic [11:0] c,
                      input logic b, input logic d,
                      input logic [23:0] e,
                      input logic we, input logic [1:0] wc,
                      input logic [3:0] wa, input logic [7:0] wd);
    u_if.pix_valid = v;
    u_if.col_in    = c;
    u_if.blank     = b;
    u_if.dim       = d;
    u_if.wr_en     = we;
    u_if.wr_ch     = wc;
    u_if.wr_addr   = wa;
    u_if.wr_data   = wd;
    if (v) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [11:0] c, input logic b,
                     input logic d, input logic [23:0] e);
    step(1'b1, c, b, d, e, 1'b0, 2'd0, 4'd0, 8'd0);
  endtask

  task automatic wr(input logic [1:0] wc, input logic [3:0] wa,
                    input logic [7:0] wd);
    step(1'b0, 12'h0, 1'b0, 1'b0, 24'h0, 1'b1, wc, wa, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 12'h0, 1'b0, 1'b0, 24'h0,
           1'b0, 2'd0, 4'd0, 8'd0);
  endtask

  initial begin
    vec_t tv[7];
    logic [7:0] curve[16];
    logic [1:0] bd[6];
    logic [23:0] bde[6];
    int cnt;
    int rdy_bad;

    tv[0] = '{12'h5A3, 1'b0, 1'b0, 24'h55AA33};
    tv[1] = '{12'hFFF, 1'b0, 1'b0, 24'hFFFFFF};
    tv[2] = '{12'hFFF, 1'b0, 1'b1, 24'h7F7F7F};
    tv[3] = '{12'hFFF, 1'b1, 1'b1, 24'h000000};
    tv[4] = '{12'h18C, 1'b0, 1'b1, 24'h084466};
    tv[5] = '{12'h123, 1'b1, 1'b0, 24'h000000};
    tv[6] = '{12'h0E7, 1'b0, 1'b0, 24'h00EE77};
    curve = '{8'h00, 8'h10, 8'h20, 8'h30,
              8'h3E, 8'h4E, 8'h5E, 8'h6E,
              8'h91, 8'hA1, 8'hB1, 8'hC1,
              8'hCF, 8'hDF, 8'hEF, 8'hFF};
    bd  = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
    bde = '{24'hFFFFFF, 24'h7F7F7F, 24'h000000,
            24'hFFFFFF, 24'h000000, 24'h7F7F7F};

    u_if.pix_valid = 1'b0;
    u_if.col_in    = '0;
    u_if.blank     = 1'b0;
    u_if.dim       = 1'b0;
    u_if.wr_en     = 1'b0;
    u_if.wr_ch     = '0;
    u_if.wr_addr   = '0;
    u_if.wr_data   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_col_out", 32'(u_if.col_out), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd1);
    chk("rst_wr_ready", 32'(u_if.wr_ready), 32'd0);

    // init with a write to [0][3] held the whole time
    rst = 1'b0;
    cnt = 0;
    rdy_bad = 0;
    u_if.wr_ch   = 2'd0;
    u_if.wr_addr = 4'd3;
    u_if.wr_data = 8'hAA;
    while (u_if.busy && cnt < 40) begin
      cnt++;
      if (u_if.wr_ready !== 1'b0) rdy_bad++;
      u_if.wr_en = 1'b1;
      @(posedge clk);
      #1;
    end
    u_if.wr_en = 1'b0;
    chk("init_cycles", 32'(cnt), 32'd16);
    chk("init_wr_ready_low", 32'(rdy_bad), 32'd0);
    chk("run_wr_ready", 32'(u_if.wr_ready), 32'd1);

    for (int i = 0; i < 7; i++)
      pix(tv[i].col, tv[i].b, tv[i].d, tv[i].exp);
    idle(3);
    chk("hold_col_out", 32'(u_if.col_out), 32'h00EE77);
    chk("hold_out_valid", 32'(u_if.out_valid), 32'd0);

    // resistor curve on channel 0
    for (int i = 0; i < 16; i++)
      wr(2'd0, 4'(i), curve[i]);
    for (int i = 0; i < 16; i++)
      pix({4'(15 - i), 4'(i), 4'(i)}, 1'b0, 1'b0,
          {rp(4'(15 - i)), rp(4'(i)), curve[i]});
    idle(3);

    for (int i = 0; i < 6; i++)
      pix(12'hFFF, bd[i][1], bd[i][0], bde[i]);
    idle(3);

    // read-before-write and out-of-range channel
    wr(2'd1, 4'd7, 8'h77);
    step(1'b1, 12'h070, 1'b0, 1'b0, 24'h007700,
         1'b1, 2'd1, 4'd7, 8'h12);
    step(1'b1, 12'h070, 1'b0, 1'b0, 24'h001200,
         1'b1, 2'd3, 4'd7, 8'h99);
    step(1'b1, 12'h070, 1'b0, 1'b0, 24'h001200,
         1'b1, 2'd3, 4'd0, 8'h99);
    pix(12'h000, 1'b0, 1'b0, 24'h000000);
    idle(3);

    // mid-run reset on pixel 5 of 10
    wr(2'd2, 4'd9, 8'hEE);
    for (int i = 0; i < 5; i++)
      pix(12'h900, 1'b0, 1'b0, 24'hEE0000);
    rst = 1'b1;
    u_if.pix_valid = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    chk("mid_rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(u_if.busy), 32'd1);
    rst = 1'b0;
    for (int i = 6; i < 10; i++)
      pix(12'h900, 1'b0, 1'b0, 24'h000000);
    cnt = 0;
    while (u_if.busy && cnt < 40) begin
      cnt++;
      idle(1);
    end
    chk("reinit_done", 32'(u_if.busy), 32'd0);
    pix(12'h900, 1'b0, 1'b0, 24'h990000);
    pix(12'h070, 1'b0, 1'b0, 24'h007700);
    pix(12'h00F, 1'b0, 1'b0, 24'h0000FF);
    idle(4);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
